stream_pack: RTL and testbench
==============================

# stream_pack

Width-upsizing stream stage that sits directly downstream of the forward register slice. It consumes narrow `T_WIDTH` beats over a valid/ready stream and packs `RATIO` consecutive beats into one wide output word. Words may be closed early by a `last` marker. Lane-occupancy is reported on a keep mask. Full throughput with no bubbles: one input beat per cycle, one output word every `RATIO` beats.

## Interface
- `T_WIDTH`, default 8: width of one input beat.
- `RATIO`, default 4: input beats per output word; must be ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high; clock clk.
- `s_port_data` input `T_WIDTH`: input beat.
- `s_port_valid` input 1: input beat present.
- `s_port_last` input 1: beat closes the current word, qualified by `s_port_valid`.
- `s_port_ready` output 1: stage accepts a beat this cycle.
- `m_port_data` output `T_WIDTH*RATIO`: packed word; lane k = bits `[k*T_WIDTH +: T_WIDTH]`.
- `m_port_keep` output `RATIO`: bit k set if lane k holds a written beat.
- `m_port_last` output 1: word was closed by `s_port_last`.
- `m_port_valid` output 1: packed word present.
- `m_port_ready` input 1: downstream accepts the word.

## Operation
- Two states, encoded by the `m_port_valid` register:
  - FILL (`m_port_valid`=0): collecting beats.
  - FULL (`m_port_valid`=1): word presented downstream.
- Lane counter `cnt`, width `$clog2(RATIO)`, selects the lane for the next accepted beat.
- `s_port_ready` = `!m_port_valid || m_port_ready`. It is combinational, with no path from `s_port_valid`.
- An input beat is accepted when `s_port_valid && s_port_ready`.
- Accepted beat, when the stage is FILL or the word is being drained this cycle:
  - Write the beat into lane `cnt` and set `keep[cnt]`.
  - If `cnt == RATIO-1` or `s_port_last`: go to FULL, set `m_port_last` = `s_port_last`, and set `cnt` = 0.
  - Otherwise: `cnt` += 1 and stay in FILL.
- Starting a new word (`cnt` = 0 on accept): all other lanes of data and keep are cleared in the same cycle. Unwritten lanes are always zero.
- Output handshake (`m_port_valid && m_port_ready`) with no accepted beat: go to FILL, clear keep and last. Data holds its value, but is don't-care.
- Simultaneous drain and accept: the drained word leaves, and the new beat lands in lane 0 of a fresh word. No bubble.
- While FULL and not drained, `s_port_ready`=0 and every register holds its value.
- `s_port_last` on lane `RATIO-1` behaves as a full word with `m_port_last`=1.
- `s_port_last` on lane 0 produces keep = `0…01`.

## Timing
- Reset values: `m_port_data`=0, `m_port_keep`=0, `m_port_last`=0, `m_port_valid`=0, `cnt`=0. Therefore `s_port_ready`=1 immediately after reset.
- While `reset` is high, input handshakes are ignored.
- Reset mid-word discards the partial word; no output is produced.
- Latency: `m_port_valid` rises in the cycle after the closing beat is accepted.
- Output stability: once `m_port_valid`=1, the word, keep and last stay stable until the handshake.
- Sustained throughput with `m_port_ready`=1: `RATIO` input beats per word, `s_port_ready` constantly 1.
- Downstream stall: backpressure reaches `s_port_ready` in the same cycle.

## Structure
- Shared package `stream_pkg`: reset-level constant and `$clog2` helper width functions.
- One sub-module is natural: `stream_pack_lane_wr`. It is a decoder from `cnt` to a one-hot lane-enable that drives the data and keep writes.
- The rest is a single module of roughly 150 lines.

## Test plan
- **Full words, `RATIO`=4, ready=1.** Stimulus: beats 0x11, 0x22, 0x33, 0x44 back-to-back. Required: one word 0x44332211, keep=0xF, last=0, asserted one cycle after the 0x44 beat; `s_port_ready` never drops.
- **Early last.** Stimulus: beats 0xA1, 0xB2 with last on 0xB2. Required: word 0x0000B2A1, keep=0x3, last=1. The next beat 0xC3 lands in lane 0.
- **Backpressure.** Stimulus: word completes, then `m_port_ready`=0 for 5 cycles. Required: `s_port_ready`=0 and the output stays stable for all 5 cycles. On release, the drain and the next beat's acceptance occur in the same cycle.
- **Single-beat last.** Stimulus: beat 0x5A with last while `cnt`=0. Required: word 0x0000005A, keep=0x1, last=1.
- **Reset mid-word.** Stimulus: 2 beats accepted, then `reset` high for 1 cycle, then 4 beats 0x01–0x04. Required: outputs zeroed during reset; a single word 0x04030201 follows, with no trace of the old beats.
- **Random soak.** Stimulus: random valid, ready and last, `RATIO`=2 and `RATIO`=8. Required: a scoreboard reconstructs the input stream exactly from the packed words and their keep masks.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width-conversion stages: reset level,
// pack FSM states and parameter-derived widths.
package stream_pkg;

    localparam logic RESET_ACTIVE = 1'b1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

    // A single-lane counter still needs one bit so the port never collapses.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int word_width(input int t_width, input int ratio);
        return t_width * ratio;
    endfunction

endpackage

// File: rtl/stream_pack_lane_wr.sv
// Lane-enable decoder for stream_pack: turns the lane counter into a one-hot
// write strobe, gated by the beat-accept condition.
module stream_pack_lane_wr
    import stream_pkg::*;
#(
    parameter int RATIO = 4,
    parameter int CW    = cnt_width(RATIO)
) (
    input  logic [CW-1:0]    cnt,
    input  logic             en,
    output logic [RATIO-1:0] lane_en
);

    always_comb begin
        lane_en = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (en && (cnt == CW'(k))) begin
                lane_en[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_pack.sv
// Width-upsizing stream stage: packs RATIO narrow beats into one wide word,
// closing early on s_port_last and reporting written lanes on m_port_keep.
module stream_pack
    import stream_pkg::*;
#(
    parameter int T_WIDTH = 8,
    parameter int RATIO   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [T_WIDTH-1:0]         s_port_data,
    input  logic                       s_port_valid,
    input  logic                       s_port_last,
    output logic                       s_port_ready,
    output logic [T_WIDTH*RATIO-1:0]   m_port_data,
    output logic [RATIO-1:0]           m_port_keep,
    output logic                       m_port_last,
    output logic                       m_port_valid,
    input  logic                       m_port_ready
);

    localparam int CW = cnt_width(RATIO);
    localparam int WW = word_width(T_WIDTH, RATIO);

    pack_state_t      state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WW-1:0]    data_q, data_n;
    logic [RATIO-1:0] keep_q, keep_n;
    logic             last_q, last_n;
    logic             accept;
    logic             close;
    logic [RATIO-1:0] lane_en;

    // Ready depends only on registered state and downstream ready, never on s_port_valid.
    assign s_port_ready = (state_q == FILL) || m_port_ready;
    assign accept       = s_port_valid && s_port_ready;
    assign close        = (cnt_q == CW'(RATIO - 1)) || s_port_last;

    assign m_port_valid = (state_q == FULL);
    assign m_port_data  = data_q;
    assign m_port_keep  = keep_q;
    assign m_port_last  = last_q;

    stream_pack_lane_wr #(
        .RATIO (RATIO),
        .CW    (CW)
    ) u_lane_wr (
        .cnt     (cnt_q),
        .en      (accept),
        .lane_en (lane_en)
    );

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            keep_q  <= keep_n;
            last_q  <= last_n;
        end
    end

    // An accept implies FILL or a same-cycle drain, so a beat at cnt 0 always opens a fresh word.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        keep_n  = keep_q;
        last_n  = last_q;
        if (accept) begin
            if (cnt_q == '0) begin
                data_n = '0;
                keep_n = '0;
            end
            for (int k = 0; k < RATIO; k++) begin
                if (lane_en[k]) begin
                    data_n[k*T_WIDTH +: T_WIDTH] = s_port_data;
                    keep_n[k]                    = 1'b1;
                end
            end
            if (close) begin
                state_n = FULL;
                last_n  = s_port_last;
                cnt_n   = '0;
            end else begin
                state_n = FILL;
                last_n  = 1'b0;
                cnt_n   = cnt_q + CW'(1);
            end
        end else if ((state_q == FULL) && m_port_ready) begin
            state_n = FILL;
            keep_n  = '0;
            last_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_pack.sv
// Self-checking bench for stream_pack: directed scenarios on a RATIO=4 instance
// and a random soak on RATIO=2 and RATIO=8 instances, all scoreboard-driven.
module tb_stream_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last, m_valid, m_ready;

    logic        sel;
    logic [7:0]  k_data;
    logic        k_valid, k_last, k_mready;
    logic        r2_sready, r2_mlast, r2_mvalid;
    logic [15:0] r2_mdata;
    logic [1:0]  r2_keep;
    logic        r8_sready, r8_mlast, r8_mvalid;
    logic [63:0] r8_mdata;
    logic [7:0]  r8_keep;
    logic        k_sready, k_mvalid, k_mlast;
    logic [63:0] k_mdata;
    logic [7:0]  k_keep;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    word_t exp_q[$];
    beat_t beat_q[$];
    int checks = 0;
    int errors = 0;

    stream_pack #(.T_WIDTH(8), .RATIO(4)) dut (
        .clk(clk), .reset(reset),
        .s_port_data(s_data), .s_port_valid(s_valid), .s_port_last(s_last), .s_port_ready(s_ready),
        .m_port_data(m_data), .m_port_keep(m_keep), .m_port_last(m_last), .m_port_valid(m_valid),
        .m_port_ready(m_ready)
    );

    stream_pack #(.T_WIDTH(8), .RATIO(2)) dut2 (
        .clk(clk), .reset(reset),
        .s_port_data(k_data), .s_port_valid(k_valid && !sel), .s_port_last(k_last), .s_port_ready(r2_sready),
        .m_port_data(r2_mdata), .m_port_keep(r2_keep), .m_port_last(r2_mlast), .m_port_valid(r2_mvalid),
        .m_port_ready(k_mready)
    );

    stream_pack #(.T_WIDTH(8), .RATIO(8)) dut8 (
        .clk(clk), .reset(reset),
        .s_port_data(k_data), .s_port_valid(k_valid && sel), .s_port_last(k_last), .s_port_ready(r8_sready),
        .m_port_data(r8_mdata), .m_port_keep(r8_keep), .m_port_last(r8_mlast), .m_port_valid(r8_mvalid),
        .m_port_ready(k_mready)
    );

    assign k_sready = sel ? r8_sready : r2_sready;
    assign k_mvalid = sel ? r8_mvalid : r2_mvalid;
    assign k_mlast  = sel ? r8_mlast  : r2_mlast;
    assign k_mdata  = sel ? r8_mdata  : {48'b0, r2_mdata};
    assign k_keep   = sel ? r8_keep   : {6'b0, r2_keep};

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        m_ready = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", m_valid); end
        checks++; if (m_keep !== 4'h0) begin errors++; $display("[TB] FAIL reset_keep got %h exp 0", m_keep); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b exp 0", m_last); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", s_ready); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_words();
        word_t e;
        exp_q.push_back('{32'h44332211, 4'hF, 1'b0});
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            #1;
            checks++;
            if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL full_fill beat %0d got ready=%b valid=%b exp ready=1 valid=0", i, s_ready, m_valid);
            end
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_latency got valid=%b exp 1", m_valid); end
        e = exp_q.pop_front();
        checks++;
        if ({m_data, m_keep, m_last} !== {e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL full_word got %h/%h/%b exp %h/%h/%b", m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain got valid=%b exp 0", m_valid); end
    endtask

    task automatic test_early_last();
        word_t e;
        logic [7:0] tail [3];
        tail[0] = 8'hD4; tail[1] = 8'hE5; tail[2] = 8'hF6;
        exp_q.push_back('{32'h0000B2A1, 4'h3, 1'b1});
        exp_q.push_back('{32'hF6E5D4C3, 4'hF, 1'b0});
        m_ready = 1'b1;
        @(negedge clk); drive(1'b1, 8'hA1, 1'b0);
        @(negedge clk); drive(1'b1, 8'hB2, 1'b1);
        @(negedge clk); drive(1'b1, 8'hC3, 1'b0);
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_valid got %b exp 1", m_valid); end
        e = exp_q.pop_front();
        checks++;
        if ({m_data, m_keep, m_last} !== {e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL early_word got %h/%h/%b exp %h/%h/%b", m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL early_ready got %b exp 1", s_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, tail[i], 1'b0);
            if (i == 0) begin
                #1;
                checks++;
                if ({m_valid, m_keep, m_data[7:0]} !== {1'b0, 4'h1, 8'hC3}) begin
                    errors++; $display("[TB] FAIL early_lane0 got valid=%b keep=%h lane0=%h exp 0/1/c3", m_valid, m_keep, m_data[7:0]);
                end
            end
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL early_next got %b/%h/%h/%b exp 1/%h/%h/%b", m_valid, m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        word_t e;
        exp_q.push_back('{32'h13121110, 4'hF, 1'b0});
        exp_q.push_back('{32'h23222120, 4'hF, 1'b0});
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            if (i == 3) m_ready = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, 8'h20, 1'b0);
            #1;
            checks++;
            if (s_ready !== 1'b0 || {m_valid, m_data, m_keep, m_last} !== {1'b1, exp_q[0].data, exp_q[0].keep, exp_q[0].last}) begin
                errors++; $display("[TB] FAIL stall cycle %0d got ready=%b %b/%h/%h/%b exp ready=0 1/%h/%h/%b",
                                   c, s_ready, m_valid, m_data, m_keep, m_last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
            end
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b exp 1", s_ready); end
        e = exp_q.pop_front();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL release_word got %b/%h/%h/%b exp 1/%h/%h/%b", m_valid, m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
        drive(1'b1, 8'h21, 1'b0);
        #1;
        checks++;
        if ({m_valid, m_keep} !== {1'b0, 4'h1}) begin
            errors++; $display("[TB] FAIL release_accept got valid=%b keep=%h exp 0/1", m_valid, m_keep);
        end
        @(negedge clk); drive(1'b1, 8'h22, 1'b0);
        @(negedge clk); drive(1'b1, 8'h23, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL bp_next got %b/%h/%h/%b exp 1/%h/%h/%b", m_valid, m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
    endtask

    task automatic test_single_last();
        word_t e;
        exp_q.push_back('{32'h0000005A, 4'h1, 1'b1});
        m_ready = 1'b1;
        @(negedge clk); drive(1'b1, 8'h5A, 1'b1);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL single_word got %b/%h/%h/%b exp 1/%h/%h/%b", m_valid, m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        word_t e;
        exp_q.push_back('{32'h04030201, 4'hF, 1'b0});
        m_ready = 1'b1;
        @(negedge clk); drive(1'b1, 8'hEE, 1'b0);
        @(negedge clk); drive(1'b1, 8'hEF, 1'b0);
        @(negedge clk); reset = 1'b1; drive(1'b1, 8'h99, 1'b0);
        @(negedge clk); reset = 1'b0; drive(1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if ({m_valid, m_keep, m_last, m_data} !== 38'h0) begin
            errors++; $display("[TB] FAIL midreset_zero got %b/%h/%b/%h exp all zero", m_valid, m_keep, m_last, m_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(i + 1), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, e.data, e.keep, e.last}) begin
            errors++; $display("[TB] FAIL midreset_word got %b/%h/%h/%b exp 1/%h/%h/%b", m_valid, m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL directed_leftover got %0d words exp 0", exp_q.size()); end
    endtask

    task automatic test_soak(input logic which, input int ratio, input int cycles);
        beat_t       b;
        logic [63:0] exp_d;
        logic [7:0]  exp_k;
        logic        exp_l;
        logic        flushed;
        int          n;
        int          words;
        sel      = which;
        flushed  = 1'b0;
        words    = 0;
        beat_q.delete();
        for (int c = 0; c < cycles + 40; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                k_valid  = ($urandom_range(0, 3) != 0);
                k_data   = 8'($urandom);
                k_last   = ($urandom_range(0, 5) == 0);
                k_mready = ($urandom_range(0, 3) != 0);
            end else begin
                k_valid  = !flushed;
                k_data   = 8'($urandom);
                k_last   = 1'b1;
                k_mready = 1'b1;
            end
            #1;
            if (k_valid && k_sready) begin
                beat_q.push_back('{k_data, k_last});
                if (c >= cycles) flushed = 1'b1;
            end
            if (k_mvalid && k_mready) begin
                exp_d = '0; exp_k = '0; exp_l = 1'b0; n = 0;
                while (n < ratio && beat_q.size() > 0) begin
                    b = beat_q.pop_front();
                    exp_d[n*8 +: 8] = b.d;
                    exp_k[n]        = 1'b1;
                    exp_l           = b.l;
                    n++;
                    if (b.l) break;
                end
                words++;
                checks++;
                if ({k_mdata, k_keep, k_mlast} !== {exp_d, exp_k, exp_l}) begin
                    errors++; $display("[TB] FAIL soak_r%0d word %0d got %h/%h/%b exp %h/%h/%b",
                                       ratio, words, k_mdata, k_keep, k_mlast, exp_d, exp_k, exp_l);
                end
            end
        end
        k_valid = 1'b0;
        checks++;
        if (beat_q.size() != 0 || words == 0) begin
            errors++; $display("[TB] FAIL soak_r%0d_flush got %0d leftover beats, %0d words exp 0 leftover", ratio, beat_q.size(), words);
        end
        $display("[TB] soak RATIO=%0d checked %0d words", ratio, words);
    endtask

    initial begin
        reset    = 1'b1;
        sel      = 1'b0;
        k_valid  = 1'b0;
        k_data   = 8'h00;
        k_last   = 1'b0;
        k_mready = 1'b1;
        m_ready  = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        test_reset();
        test_full_words();
        test_early_last();
        test_backpressure();
        test_single_last();
        test_reset_mid();
        test_soak(1'b0, 2, 1500);
        test_soak(1'b1, 8, 1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
